// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq
// Purpose  : Iterative shift-and-add-3 binary-to-BCD converter, one bit per
//            clock, with registered digits and leading-zero blanking mask.
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [WIDTH-1:0]      Bin,
    output logic                  Busy,
    output logic                  Done,
    output logic [4*DIGITS-1:0]   Bcd,
    output logic [DIGITS-1:0]     BlankMask
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [DIGITS-1:0]  c_BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    // Every representable input must fit in the digit count, else the
    // top digit could overflow past 9.
    generate
        if (WIDTH < 4 || WIDTH > 16 ||
            pow10(DIGITS) <= ((longint'(1) << WIDTH) - 1)) begin : g_bad_params
            $error("bin_to_bcd_seq: unsupported WIDTH/DIGITS combination");
        end
    endgenerate

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [WIDTH-1:0]    r_shift;
    logic [c_BCD_W-1:0]  r_scratch;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_BCD_W-1:0]  r_bcd;
    logic [DIGITS-1:0]   r_blank;

    logic [c_BCD_W-1:0]  w_adj;
    logic [c_BCD_W-1:0]  w_scratch_nxt;
    logic [WIDTH-1:0]    w_shift_nxt;
    logic [DIGITS-1:0]   w_blank_nxt;
    logic                w_last;
    logic                w_unused_adj_msb;

    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_adj
            assign w_adj[4*d +: 4] = (r_scratch[4*d +: 4] >= 4'd5)
                                   ? r_scratch[4*d +: 4] + 4'd3
                                   : r_scratch[4*d +: 4];
        end
    endgenerate

    // The adjusted MSB is shifted out; it is provably zero for legal sizes.
    assign w_unused_adj_msb = w_adj[c_BCD_W-1];
    assign w_scratch_nxt    = {w_adj[c_BCD_W-2:0], r_shift[WIDTH-1]};
    assign w_shift_nxt      = {r_shift[WIDTH-2:0], 1'b0};
    assign w_last           = (r_count == c_CNT_ONE);

    assign w_blank_nxt[0] = 1'b0;
    generate
        for (genvar d = 1; d < DIGITS; d++) begin : g_blank
            assign w_blank_nxt[d] = ~|w_scratch_nxt[c_BCD_W-1:4*d];
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (Start) w_state_nxt = c_SHIFT;
            c_SHIFT: if (w_last) w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_count   <= '0;
            r_bcd     <= '0;
            r_blank   <= c_BLANK_RST;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (Start) begin
                        r_shift   <= Bin;
                        r_scratch <= '0;
                        r_count   <= c_CNT_LOAD;
                    end
                end
                c_SHIFT: begin
                    r_shift   <= w_shift_nxt;
                    r_scratch <= w_scratch_nxt;
                    r_count   <= r_count - c_CNT_ONE;
                    if (w_last) begin
                        r_bcd   <= w_scratch_nxt;
                        r_blank <= w_blank_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Busy      = (r_state == c_SHIFT);
    assign Done      = (r_state == c_DONE);
    assign Bcd       = r_bcd;
    assign BlankMask = r_blank;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_bcd_seq
// Purpose  : Self-checking bench for bin_to_bcd_seq against a decimal model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

    localparam int c_WIDTH  = 10;
    localparam int c_DIGITS = 4;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [9:0]  Bin;
    logic        Busy;
    logic        Done;
    logic [15:0] Bcd;
    logic [3:0]  BlankMask;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq #(.WIDTH(c_WIDTH), .DIGITS(c_DIGITS)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Bin(Bin),
        .Busy(Busy), .Done(Done), .Bcd(Bcd), .BlankMask(BlankMask)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Digit i and all above are zero exactly when v < 10^i.
    function automatic logic [3:0] ref_blank(input int v);
        logic [3:0] m;
        int p;
        m = '0;
        p = 10;
        for (int i = 1; i < 4; i++) begin
            m[i] = (v < p);
            p = p * 10;
        end
        return m;
    endfunction

    function automatic bit digits_legal(input logic [15:0] b);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Stimulus only: one request issued from an idle negedge, then
    // WIDTH+6 samples taken on following negedges.
    task automatic run_one(input logic [9:0] v, output int nbusy, output int ndone,
                           output int done_at, output logic [15:0] bcd_at_done);
        Start = 1'b1;
        Bin   = v;
        nbusy = 0;
        ndone = 0;
        done_at = -1;
        bcd_at_done = 'x;
        for (int s = 1; s <= c_WIDTH + 6; s++) begin
            @(negedge Clk);
            Start = 1'b0;
            Bin   = 10'($urandom);
            if (Busy) nbusy++;
            if (Done) begin
                ndone++;
                done_at = s;
                bcd_at_done = Bcd;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b0;
        Bin   = '0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({Busy, Done, Bcd, BlankMask} !== {1'b0, 1'b0, 16'h0000, 4'b1110}) begin
            errors++;
            $display("FAIL reset_hold got %b_%b_%h_%b want 0_0_0000_1110", Busy, Done, Bcd, BlankMask);
        end
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            checks++;
            if ({Busy, Done, Bcd, BlankMask} !== {1'b0, 1'b0, 16'h0000, 4'b1110}) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got %b_%b_%h_%b want 0_0_0000_1110", i, Busy, Done, Bcd, BlankMask);
            end
        end
    endtask

    task automatic test_max();
        int nb, nd, da;
        logic [15:0] bd;
        run_one(10'd1023, nb, nd, da, bd);
        checks++;
        if (nb != c_WIDTH || nd != 1 || da != c_WIDTH + 1) begin
            errors++;
            $display("FAIL max_timing got busy=%0d done=%0d at=%0d want busy=10 done=1 at=11", nb, nd, da);
        end
        checks++;
        if (bd !== 16'h1023 || Bcd !== 16'h1023 || BlankMask !== 4'b0000) begin
            errors++;
            $display("FAIL max_value got %h/%h mask %b want 1023 mask 0000", bd, Bcd, BlankMask);
        end
    endtask

    task automatic test_small();
        int nb, nd, da;
        logic [15:0] bd;
        run_one(10'd7, nb, nd, da, bd);
        checks++;
        if (Bcd !== 16'h0007 || BlankMask !== 4'b1110) begin
            errors++;
            $display("FAIL small_7 got %h mask %b want 0007 mask 1110", Bcd, BlankMask);
        end
        run_one(10'd0, nb, nd, da, bd);
        checks++;
        if (Bcd !== 16'h0000 || BlankMask !== 4'b1110 || nd != 1) begin
            errors++;
            $display("FAIL small_0 got %h mask %b done=%0d want 0000 mask 1110 done=1", Bcd, BlankMask, nd);
        end
    endtask

    task automatic test_ignored_start();
        int nb, nd, da;
        Start = 1'b1;
        Bin   = 10'd999;
        nb = 0; nd = 0; da = -1;
        for (int s = 1; s <= c_WIDTH + 6; s++) begin
            @(negedge Clk);
            Start = (s == 3);
            Bin   = (s == 3) ? 10'd5 : 10'($urandom);
            if (Busy) nb++;
            if (Done) begin
                nd++;
                da = s;
            end
        end
        checks++;
        if (nb != c_WIDTH || nd != 1 || da != c_WIDTH + 1) begin
            errors++;
            $display("FAIL ignored_timing got busy=%0d done=%0d at=%0d want busy=10 done=1 at=11", nb, nd, da);
        end
        checks++;
        if (Bcd !== 16'h0999 || BlankMask !== 4'b1000) begin
            errors++;
            $display("FAIL ignored_value got %h mask %b want 0999 mask 1000", Bcd, BlankMask);
        end
    endtask

    task automatic test_abort();
        int nd, nb, da;
        logic [15:0] bd;
        Start = 1'b1;
        Bin   = 10'd512;
        nd = 0;
        for (int s = 1; s <= 4; s++) begin
            @(negedge Clk);
            Start = 1'b0;
            if (Done) nd++;
        end
        Reset = 1'b1;
        @(negedge Clk);
        checks++;
        if ({Busy, Done, Bcd, BlankMask} !== {1'b0, 1'b0, 16'h0000, 4'b1110}) begin
            errors++;
            $display("FAIL abort_reset got %b_%b_%h_%b want 0_0_0000_1110", Busy, Done, Bcd, BlankMask);
        end
        Reset = 1'b0;
        for (int s = 0; s < c_WIDTH + 4; s++) begin
            @(negedge Clk);
            if (Done || Busy) nd++;
        end
        checks++;
        if (nd != 0) begin
            errors++;
            $display("FAIL abort_no_done got activity=%0d want 0", nd);
        end
        run_one(10'd88, nb, nd, da, bd);
        checks++;
        if (Bcd !== 16'h0088 || BlankMask !== 4'b1100 || da != c_WIDTH + 1) begin
            errors++;
            $display("FAIL abort_next got %h mask %b at=%0d want 0088 mask 1100 at=11", Bcd, BlankMask, da);
        end
    endtask

    task automatic test_reset_start_collide();
        int act;
        Reset = 1'b1;
        Start = 1'b1;
        Bin   = 10'd321;
        @(negedge Clk);
        Reset = 1'b0;
        Start = 1'b0;
        act = 0;
        for (int s = 0; s < c_WIDTH + 4; s++) begin
            @(negedge Clk);
            if (Busy || Done) act++;
        end
        checks++;
        if (act != 0 || Bcd !== 16'h0000) begin
            errors++;
            $display("FAIL collide got activity=%0d bcd=%h want 0 0000", act, Bcd);
        end
    endtask

    task automatic test_random();
        int nb, nd, da, bad;
        int v;
        logic [15:0] bd;
        bad = 0;
        for (int n = 0; n < 40; n++) begin
            v = int'($urandom_range(0, 1023));
            run_one(10'(v), nb, nd, da, bd);
            checks++;
            if (Bcd !== ref_bcd(v) || BlankMask !== ref_blank(v) || nd != 1) begin
                errors++;
                $display("FAIL random v=%0d got %h mask %b want %h mask %b", v, Bcd, BlankMask, ref_bcd(v), ref_blank(v));
            end
        end
    endtask

    task automatic test_exhaustive();
        int nb, nd, da;
        logic [15:0] bd;
        for (int v = 0; v < 1024; v++) begin
            run_one(10'(v), nb, nd, da, bd);
            checks++;
            if (bd !== ref_bcd(v) || BlankMask !== ref_blank(v) || !digits_legal(bd)
                || nd != 1 || nb != c_WIDTH || da != c_WIDTH + 1) begin
                errors++;
                $display("FAIL exh_seq v=%0d got %h mask %b busy=%0d done=%0d at=%0d want %h mask %b",
                         v, bd, BlankMask, nb, nd, da, ref_bcd(v), ref_blank(v));
            end
        end
    endtask

    task automatic test_back_to_back();
        int cur, cyc, last;
        bit set_next, rand_next;
        cur = 0; cyc = 0; last = -1;
        set_next = 1'b0;
        rand_next = 1'b1;
        Start = 1'b1;
        Bin   = 10'd0;
        for (int c = 0; c < 1024 * 12 + 40 && cur < 1024; c++) begin
            @(negedge Clk);
            cyc++;
            if (rand_next) begin
                Bin = 10'($urandom);
                rand_next = 1'b0;
            end
            if (Done) begin
                checks++;
                if (Bcd !== ref_bcd(cur) || BlankMask !== ref_blank(cur) || !digits_legal(Bcd)) begin
                    errors++;
                    $display("FAIL b2b_value v=%0d got %h mask %b want %h mask %b",
                             cur, Bcd, BlankMask, ref_bcd(cur), ref_blank(cur));
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != c_WIDTH + 2) begin
                        errors++;
                        $display("FAIL b2b_spacing v=%0d got %0d want 12", cur, cyc - last);
                    end
                end
                last = cyc;
                cur++;
                set_next = 1'b1;
                if (cur == 1024) Start = 1'b0;
            end else if (set_next) begin
                Bin = 10'(cur);
                set_next = 1'b0;
                rand_next = 1'b1;
            end
        end
        Start = 1'b0;
        checks++;
        if (cur != 1024) begin
            errors++;
            $display("FAIL b2b_timeout got %0d conversions want 1024", cur);
        end
        repeat (4) @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        Bin   = '0;
        test_reset();
        test_max();
        test_small();
        test_ignored_start();
        test_abort();
        test_reset_start_collide();
        test_random();
        test_exhaustive();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
